rr_arbiter_ctrl: RTL and testbench



---
 rtl/sync_arb_pkg.sv | 15 +
 rtl/rr_arbiter_ctrl_if.sv | 27 ++
 rtl/rr_priority_pick.sv | 46 ++++
 rtl/rr_arbiter_ctrl.sv | 127 ++++++++++++
 tb/tb_rr_arbiter_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/sync_arb_pkg.sv
// Shared types and width helpers for the round-robin arbiter.
package sync_arb_pkg;

  // Arbiter control state: no owner, or one owner holding the grant.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Width of a field able to hold indices 0..v-1; never narrower than one bit.
  function automatic int arb_width(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/rr_arbiter_ctrl_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_arbiter_ctrl_if #(
  parameter int N = 32
);
  import sync_arb_pkg::*;

  localparam int IDW = arb_width(N);

  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           timeout;

  // Requester side drives req and observes the grant.
  modport master (
    output req,
    input  gnt, gnt_valid, gnt_id, timeout
  );

  // Arbiter side samples req and drives the grant.
  modport slave (
    input  req,
    output gnt, gnt_valid, gnt_id, timeout
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: lowest set bit at or above ptr, wrapping.
module rr_priority_pick
  import sync_arb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]            req_i,
  input  logic [arb_width(N)-1:0] ptr_i,
  output logic [N-1:0]            onehot_o,
  output logic [arb_width(N)-1:0] idx_o,
  output logic                    any_o
);

  localparam int IDW = arb_width(N);
  localparam logic [IDW:0] N_W = (IDW+1)'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDW:0]   off;
  logic [IDW:0]   sum;

  // Rotate the doubled vector so ptr lands at bit 0, scan for the first set
  // bit, then add ptr back (mod N) to recover the absolute index.
  always_comb begin
    dbl      = {req_i, req_i};
    rot      = dbl[ptr_i +: N];
    off      = '0;
    any_o    = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = (IDW+1)'(k);
        any_o = 1'b1;
      end
    end
    sum = off + {1'b0, ptr_i};
    if (sum >= N_W) begin
      sum = sum - N_W;
    end
    idx_o    = sum[IDW-1:0];
    onehot_o = '0;
    if (any_o) begin
      onehot_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter_ctrl.sv
// Round-robin arbiter with registered one-hot grant, hold limit and penalty.
module rr_arbiter_ctrl
  import sync_arb_pkg::*;
#(
  parameter int N        = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  rr_arbiter_ctrl_if.slave bus
);

  localparam int IDW = arb_width(N);
  localparam int CW  = arb_width(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
  localparam logic [IDW:0]  N_W      = (IDW+1)'(N);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [CW-1:0]  hold_q, hold_d;
  logic [N-1:0]   penalty_q, penalty_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           gnt_valid_q, gnt_valid_d;
  logic           timeout_q, timeout_d;

  logic [N-1:0]   eligible;
  logic [N-1:0]   pick_onehot;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic [IDW:0]   id_inc;
  logic [IDW-1:0] next_ptr;
  logic           owner_req;

  assign eligible  = bus.req & ~penalty_q;
  assign owner_req = bus.req[gnt_id_q];
  assign id_inc    = {1'b0, gnt_id_q} + (IDW+1)'(1);
  assign next_ptr  = (id_inc == N_W) ? '0 : id_inc[IDW-1:0];

  rr_priority_pick #(.N(N)) u_pick (
    .req_i    (eligible),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // Next-state and output decode; every register defaults to holding.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_id_d    = gnt_id_q;
    hold_d      = hold_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    // A penalised requester is forgiven as soon as it is seen low.
    penalty_d   = penalty_q & bus.req;
    case (state_q)
      IDLE: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        if (pick_any) begin
          gnt_d       = pick_onehot;
          gnt_valid_d = 1'b1;
          gnt_id_d    = pick_idx;
          hold_d      = CW'(1);
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (!owner_req) begin
          // Voluntary release wins even when the limit is reached this edge.
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = next_ptr;
          hold_d      = '0;
          state_d     = IDLE;
        end else if ((MAX_HOLD != 0) && (hold_q == HOLD_MAX)) begin
          gnt_d               = '0;
          gnt_valid_d         = 1'b0;
          timeout_d           = 1'b1;
          penalty_d[gnt_id_q] = 1'b1;
          ptr_d               = next_ptr;
          hold_d              = '0;
          state_d             = IDLE;
        end else if ((MAX_HOLD != 0) && (hold_q != HOLD_MAX)) begin
          hold_d = hold_q + CW'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_id_q    <= '0;
      hold_q      <= '0;
      penalty_q   <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_id_q    <= gnt_id_d;
      hold_q      <= hold_d;
      penalty_q   <= penalty_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Directed, table-driven bench for rr_arbiter_ctrl (N=4; MAX_HOLD=4 and 0).
module tb_rr_arbiter_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rr_arbiter_ctrl_if #(.N(4)) bus  ();
  rr_arbiter_ctrl_if #(.N(4)) bus0 ();

  rr_arbiter_ctrl #(.N(4), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rr_arbiter_ctrl #(.N(4), .MAX_HOLD(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic       valid;
    logic [1:0] id;
    logic       to;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] g, input logic v,
                     input logic [1:0] id, input logic to);
    vec_t e;
    e.req = r; e.gnt = g; e.valid = v; e.id = id; e.to = to;
    vecs.push_back(e);
  endtask

  // Drive both request vectors before an edge, then settle just after it.
  task automatic step(input logic [3:0] r, input logic [3:0] r0);
    @(negedge clk);
    bus.req  = r;
    bus0.req = r0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic inv_ok(input logic [3:0] g, input logic v, input logic [1:0] id);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    return ($countones(g) <= 1) && (v == (|g)) && (!v || (g == oh));
  endfunction

  // Structural invariants on both instances, every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("inv_dut",  32'(inv_ok(bus.gnt,  bus.gnt_valid,  bus.gnt_id)),  32'd1);
      check("inv_dut0", 32'(inv_ok(bus0.gnt, bus0.gnt_valid, bus0.gnt_id)), 32'd1);
    end
  end

  initial begin
    // rotation 0,1,2,3,0 with one dead cycle between grants
    add(4'b1111, 4'b0001, 1, 2'd0, 0);
    add(4'b1111, 4'b0001, 1, 2'd0, 0);
    add(4'b1110, 4'b0000, 0, 2'd0, 0);
    add(4'b1111, 4'b0010, 1, 2'd1, 0);
    add(4'b1111, 4'b0010, 1, 2'd1, 0);
    add(4'b1101, 4'b0000, 0, 2'd1, 0);
    add(4'b1111, 4'b0100, 1, 2'd2, 0);
    add(4'b1111, 4'b0100, 1, 2'd2, 0);
    add(4'b1011, 4'b0000, 0, 2'd2, 0);
    add(4'b1111, 4'b1000, 1, 2'd3, 0);
    add(4'b1111, 4'b1000, 1, 2'd3, 0);
    add(4'b0111, 4'b0000, 0, 2'd3, 0);
    add(4'b1111, 4'b0001, 1, 2'd0, 0);
    add(4'b1110, 4'b0000, 0, 2'd0, 0);
    // move ptr to 3, then wrap-and-skip with req=0110
    add(4'b0100, 4'b0100, 1, 2'd2, 0);
    add(4'b0000, 4'b0000, 0, 2'd2, 0);
    add(4'b0110, 4'b0010, 1, 2'd1, 0);
    add(4'b0110, 4'b0010, 1, 2'd1, 0);
    add(4'b0100, 4'b0000, 0, 2'd1, 0);
    add(4'b0110, 4'b0100, 1, 2'd2, 0);
    add(4'b0000, 4'b0000, 0, 2'd2, 0);
    add(4'b0000, 4'b0000, 0, 2'd2, 0);
    add(4'b0001, 4'b0001, 1, 2'd0, 0);
    add(4'b0000, 4'b0000, 0, 2'd0, 0);
    // timeout: req[2] high for 10 cycles, 4 granted, revoke pulse, no regrant
    for (int i = 0; i < 4; i++) add(4'b0100, 4'b0100, 1, 2'd2, 0);
    add(4'b0100, 4'b0000, 0, 2'd2, 1);
    for (int i = 0; i < 5; i++) add(4'b0100, 4'b0000, 0, 2'd2, 0);
    add(4'b0000, 4'b0000, 0, 2'd2, 0);
    add(4'b0100, 4'b0100, 1, 2'd2, 0);
    add(4'b0000, 4'b0000, 0, 2'd2, 0);
    // release on the same edge the limit is reached: normal release
    for (int i = 0; i < 4; i++) add(4'b0010, 4'b0010, 1, 2'd1, 0);
    add(4'b0000, 4'b0000, 0, 2'd1, 0);
    add(4'b0010, 4'b0010, 1, 2'd1, 0);
    add(4'b0000, 4'b0000, 0, 2'd1, 0);
    // other requesters toggling while busy do not disturb the owner
    add(4'b1000, 4'b1000, 1, 2'd3, 0);
    add(4'b1111, 4'b1000, 1, 2'd3, 0);
    add(4'b0111, 4'b0000, 0, 2'd3, 0);

    bus.req  = '0;
    bus0.req = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_gnt",   32'(bus.gnt),       32'd0);
    check("reset_valid", 32'(bus.gnt_valid), 32'd0);
    check("reset_id",    32'(bus.gnt_id),    32'd0);
    check("reset_to",    32'(bus.timeout),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].req, 4'b0000);
      check($sformatf("v%0d_gnt", i),   32'(bus.gnt),       32'(vecs[i].gnt));
      check($sformatf("v%0d_valid", i), 32'(bus.gnt_valid), 32'(vecs[i].valid));
      check($sformatf("v%0d_id", i),    32'(bus.gnt_id),    32'(vecs[i].id));
      check($sformatf("v%0d_to", i),    32'(bus.timeout),   32'(vecs[i].to));
      $display("vec %0d req=%b gnt=%b valid=%b id=%0d to=%b",
               i, vecs[i].req, bus.gnt, bus.gnt_valid, bus.gnt_id, bus.timeout);
    end

    // MAX_HOLD=0: grant held indefinitely, never revoked
    for (int i = 0; i < 100; i++) begin
      step(4'b0000, 4'b0001);
      check("nohold_gnt", 32'(bus0.gnt),     32'b0001);
      check("nohold_to",  32'(bus0.timeout), 32'd0);
    end
    $display("nohold: 100 cycles gnt=%b", bus0.gnt);
    step(4'b0000, 4'b0000);
    check("nohold_release", 32'(bus0.gnt), 32'd0);

    // asynchronous reset in the middle of a grant
    step(4'b0100, 4'b0000);
    check("prereset_gnt", 32'(bus.gnt), 32'b0100);
    #1 rst = 1'b1;
    #1;
    check("async_gnt",   32'(bus.gnt),       32'd0);
    check("async_valid", 32'(bus.gnt_valid), 32'd0);
    check("async_to",    32'(bus.timeout),   32'd0);
    check("async_id",    32'(bus.gnt_id),    32'd0);
    bus.req = 4'b0001;
    rst     = 1'b0;
    step(4'b0001, 4'b0000);
    check("postreset_gnt", 32'(bus.gnt),    32'b0001);
    check("postreset_id",  32'(bus.gnt_id), 32'd0);
    $display("reset: gnt=%b id=%0d after first edge", bus.gnt, bus.gnt_id);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
